// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller (master) and the
// data memory or bus fabric (slave). A request is held until ack or err.
interface mem_access_ctrl_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic        dm_err;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_ack, dm_err, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_ack, dm_err, dm_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer.
// Issues one bus request per load/store, waits for ack, err or timeout, then
// lets the instruction advance into MEM_MID with a fault flag. Upstream
// stages are held through mem_busy while an access is outstanding. An
// interrupt flush that arrives before the bus has answered still has to let
// the bus finish, so it parks in ABORT and discards the answer.
module mem_access_ctrl #(
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 200
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                int_clr,
  input  logic                stall_in,
  input  logic                load_in,
  input  logic                store_in,
  input  logic [31:0]         addr_in,
  input  logic [31:0]         wdata_in,
  input  logic [3:0]          be_in,
  mem_access_ctrl_if.master   dm,
  output logic [31:0]         rdata_out,
  output logic                mmid_en,
  output logic                mmid_clr,
  output logic                mem_busy,
  output logic                bus_exc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_ABORT
  } state_e;

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_MAX);

  state_e           state;
  logic [TMO_W-1:0] cnt;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic             dm_req_c;

  // Any bus completion, used where ack and err are treated alike.
  logic bus_done;
  assign bus_done = dm.dm_ack | dm.dm_err;

  assign dm.dm_req   = dm_req_c;
  assign dm.dm_we    = we_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_wdata = wdata_q;
  assign dm.dm_be    = be_q;

  // State sequencing, request latching, wait counter and captured results.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_out <= '0;
      bus_exc   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // A flush wins over a newly arrived memory op; nothing is issued.
          if (!int_clr && (load_in || store_in)) begin
            addr_q  <= addr_in;
            wdata_q <= wdata_in;
            be_q    <= be_in;
            we_q    <= store_in;
            cnt     <= '0;
            bus_exc <= 1'b0;
            state   <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          if (int_clr) begin
            // If the bus answers in the flush cycle the access is already
            // closed; otherwise the outstanding request must be drained.
            state <= bus_done ? S_IDLE : S_ABORT;
          end else if (dm.dm_err) begin
            bus_exc <= 1'b1;
            state   <= S_DONE;
          end else if (dm.dm_ack) begin
            if (!we_q) rdata_out <= dm.dm_rdata;
            state <= S_DONE;
          end else if (cnt == TMO_LIM) begin
            // Request is withdrawn without completion; the bus must accept it.
            bus_exc <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + TMO_W'(1);
          end
        end

        S_DONE: begin
          // Result is held here until MEM_MID can take it or it is flushed.
          if (int_clr || !stall_in) state <= S_IDLE;
        end

        S_ABORT: begin
          // Wait out the flushed access; its response is thrown away and no
          // timeout applies, the bus owes an answer.
          if (bus_done) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Pipeline-register control and bus request decoded from state and inputs.
  // NOTE: every output gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    mmid_en  = 1'b0;
    mmid_clr = 1'b0;
    mem_busy = 1'b0;
    dm_req_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (int_clr) begin
          mmid_clr = 1'b1;
        end else if (load_in || store_in) begin
          mem_busy = 1'b1;
        end else begin
          // Non-memory instructions pass through with no added latency.
          mmid_en = ~stall_in;
        end
      end

      S_ACCESS: begin
        dm_req_c = 1'b1;
        mem_busy = 1'b1;
        mmid_clr = int_clr;
      end

      S_DONE: begin
        if (int_clr) begin
          mmid_clr = 1'b1;
        end else begin
          mmid_en  = ~stall_in;
          mem_busy = 1'b1;
        end
      end

      S_ABORT: begin
        dm_req_c = 1'b1;
        mem_busy = 1'b1;
        mmid_clr = 1'b1;
      end

      default: ;
    endcase
  end

endmodule
